// File: rtl/multimode_phase_accum_pkg.sv
// Shared definitions for the multimode phase accumulator: mode encodings,
// FSM state type and default parameter values.
package multimode_phase_accum_pkg;

    localparam int unsigned DEF_PHASE_W  = 32;
    localparam int unsigned DEF_ADDR_W   = 12;
    localparam int unsigned DEF_TIMP_W   = 10;
    localparam int unsigned DEF_TPER_W   = 13;
    localparam int unsigned DEF_NIMP_W   = 5;
    localparam int unsigned DEF_DEV_W    = 22;
    localparam int unsigned DEF_CODE_LEN = 13;
    localparam int unsigned DEF_CHIP_W   = 8;

    localparam logic [1:0] MODE_CW  = 2'b00;
    localparam logic [1:0] MODE_LFM = 2'b01;
    localparam logic [1:0] MODE_PSK = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_PULSE,
        ST_GAP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/multimode_phase_accum_psk_chip_sequencer.sv
// PSK chip sequencer: chip timer, code index and the chip bit that applies
// to the sample being launched this cycle.
module psk_chip_sequencer
    import multimode_phase_accum_pkg::*;
#(
    parameter int unsigned CODE_LEN = DEF_CODE_LEN,
    parameter int unsigned CHIP_W   = DEF_CHIP_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                restart_i,
    input  logic                advance_i,
    input  logic [CODE_LEN-1:0] code_i,
    input  logic [CHIP_W-1:0]   chip_len_i,
    output logic                chip_bit_o
);

    localparam int unsigned IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CHIP_W-1:0] tmr_q, tmr_d;
    logic [CHIP_W-1:0] last_tick;

    // A chip length of 0 behaves like 1: every sample ends its chip.
    assign last_tick = (chip_len_i == '0) ? '0 : chip_len_i - CHIP_W'(1);

    // Next chip position for the sample being launched this cycle.
    always_comb begin
        idx_d = idx_q;
        tmr_d = tmr_q;
        if (restart_i) begin
            idx_d = '0;
            tmr_d = '0;
        end else if (advance_i) begin
            if (tmr_q >= last_tick) begin
                tmr_d = '0;
                idx_d = (idx_q == IDX_W'(CODE_LEN - 1)) ? '0 : idx_q + IDX_W'(1);
            end else begin
                tmr_d = tmr_q + CHIP_W'(1);
            end
        end
    end

    // Chip position of the sample currently on the output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q <= '0;
            tmr_q <= '0;
        end else begin
            idx_q <= idx_d;
            tmr_q <= tmr_d;
        end
    end

    assign chip_bit_o = code_i[idx_d];

endmodule

// File: rtl/multimode_phase_accum.sv
// Multimode (CW / LFM / BPSK) phase accumulator producing sine ROM addresses
// for bursts of pulses. PSK support is built only when MULTIMODE_PSK_EN is
// defined; otherwise PSK requests are rejected like the reserved mode.
module multimode_phase_accum
    import multimode_phase_accum_pkg::*;
#(
    parameter int unsigned PHASE_W  = DEF_PHASE_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned TIMP_W   = DEF_TIMP_W,
    parameter int unsigned TPER_W   = DEF_TPER_W,
    parameter int unsigned NIMP_W   = DEF_NIMP_W,
    parameter int unsigned DEV_W    = DEF_DEV_W,
    parameter int unsigned CODE_LEN = DEF_CODE_LEN,
    parameter int unsigned CHIP_W   = DEF_CHIP_W
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                SIGN_START_GEN,
    input  logic [1:0]          SIGNAL_TYPE,
    input  logic [PHASE_W-1:0]  F_CARRIER,
    input  logic [TIMP_W-1:0]   T_IMPULSE,
    input  logic [TPER_W-1:0]   T_PERIOD,
    input  logic [NIMP_W-1:0]   NUM_OF_IMP,
    input  logic [DEV_W-1:0]    DEVIATION,
    input  logic [CODE_LEN-1:0] PSK_CODE,
    input  logic [CHIP_W-1:0]   CHIP_LEN,
    input  logic                ABORT,
    input  logic                OUT_REG_READY,
    output logic [ADDR_W-1:0]   ROM_ADDRESS,
    output logic                ADDR_VALID,
    output logic                SIGN_START_CALC,
    output logic                SIGN_STOP_CALC,
    output logic                BUSY,
    output logic                PARAM_ERR
);

    localparam int unsigned CMP_W = (TPER_W > TIMP_W) ? TPER_W : TIMP_W;
    localparam logic [ADDR_W-1:0] ADDR_HALF = {1'b1, {(ADDR_W-1){1'b0}}};

    state_t state_q, state_d;

    logic start_s_q, start_p_q, start_rise;
    logic mode_ok, params_ok;

    logic [1:0]         mode_q;
    logic [PHASE_W-1:0] fcar_q;
    logic [TIMP_W-1:0]  timp_q;
    logic [NIMP_W-1:0]  nimp_q;
    logic [DEV_W-1:0]   dev_q;
    logic [CMP_W-1:0]   gap_len_q;
    logic               gap_en_q;
    logic [CMP_W-1:0]   tper_ext, timp_ext;
    logic [PHASE_W-1:0] dev_ext;

    logic [TIMP_W-1:0]  smp_q, smp_d;
    logic [CMP_W-1:0]   gap_q, gap_d;
    logic [NIMP_W-1:0]  imp_q, imp_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] freq_q, freq_d;

    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               valid_q, valid_d;
    logic               start_calc_q, start_calc_d;
    logic               stop_q, stop_d;
    logic               busy_q, busy_d;
    logic               perr_q, perr_d;

    logic latch, emit, restart;
    logic psk_flip;

    assign start_rise = start_s_q & ~start_p_q;
    assign tper_ext   = CMP_W'(T_PERIOD);
    assign timp_ext   = CMP_W'(T_IMPULSE);
    assign dev_ext    = PHASE_W'($signed(dev_q));

`ifdef MULTIMODE_PSK_EN
    logic [CODE_LEN-1:0] code_q;
    logic [CHIP_W-1:0]   chip_len_q;
    logic                chip_bit;

    assign mode_ok = (SIGNAL_TYPE != MODE_RSV);

    // PSK parameters captured when a burst is accepted.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            code_q     <= '0;
            chip_len_q <= '0;
        end else if (latch) begin
            code_q     <= PSK_CODE;
            chip_len_q <= CHIP_LEN;
        end
    end

    psk_chip_sequencer #(
        .CODE_LEN (CODE_LEN),
        .CHIP_W   (CHIP_W)
    ) u_chip_seq (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .restart_i  (emit & restart),
        .advance_i  (emit & ~restart),
        .code_i     (code_q),
        .chip_len_i (chip_len_q),
        .chip_bit_o (chip_bit)
    );

    assign psk_flip = (mode_q == MODE_PSK) & chip_bit;
`else
    logic unused_psk;

    assign mode_ok    = (SIGNAL_TYPE == MODE_CW) || (SIGNAL_TYPE == MODE_LFM);
    assign psk_flip   = 1'b0;
    assign unused_psk = ^{PSK_CODE, CHIP_LEN};
`endif

    assign params_ok = mode_ok && (T_IMPULSE != '0) && (NUM_OF_IMP != '0);

    // Burst parameters captured when a start request is accepted.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mode_q    <= MODE_CW;
            fcar_q    <= '0;
            timp_q    <= '0;
            nimp_q    <= '0;
            dev_q     <= '0;
            gap_len_q <= '0;
            gap_en_q  <= 1'b0;
        end else if (latch) begin
            mode_q    <= SIGNAL_TYPE;
            fcar_q    <= F_CARRIER;
            timp_q    <= T_IMPULSE;
            nimp_q    <= NUM_OF_IMP;
            dev_q     <= DEVIATION;
            gap_len_q <= tper_ext - timp_ext;
            gap_en_q  <= (tper_ext > timp_ext);
        end
    end

    // Sequencing: next state, pulse/gap counters and strobes. "emit" means a
    // sample is launched at this edge; "restart" makes it sample 0 of a pulse.
    always_comb begin
        state_d      = state_q;
        smp_d        = smp_q;
        gap_d        = gap_q;
        imp_d        = imp_q;
        busy_d       = busy_q;
        start_calc_d = 1'b0;
        stop_d       = 1'b0;
        perr_d       = 1'b0;
        latch        = 1'b0;
        emit         = 1'b0;
        restart      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    if (params_ok) begin
                        latch   = 1'b1;
                        busy_d  = 1'b1;
                        state_d = ST_ARM;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            end
            ST_ARM: begin
                if (ABORT) begin
                    state_d = ST_DONE;
                end else if (OUT_REG_READY) begin
                    state_d      = ST_PULSE;
                    emit         = 1'b1;
                    restart      = 1'b1;
                    start_calc_d = 1'b1;
                    imp_d        = '0;
                end
            end
            ST_PULSE: begin
                if (ABORT) begin
                    state_d = ST_DONE;
                end else if (smp_q == timp_q - TIMP_W'(1)) begin
                    if (imp_q == nimp_q - NIMP_W'(1)) begin
                        state_d = ST_DONE;
                    end else if (gap_en_q) begin
                        state_d = ST_GAP;
                        gap_d   = '0;
                    end else begin
                        emit    = 1'b1;
                        restart = 1'b1;
                        imp_d   = imp_q + NIMP_W'(1);
                    end
                end else begin
                    emit = 1'b1;
                end
            end
            ST_GAP: begin
                if (ABORT) begin
                    state_d = ST_DONE;
                end else if (gap_q == gap_len_q - CMP_W'(1)) begin
                    state_d = ST_PULSE;
                    emit    = 1'b1;
                    restart = 1'b1;
                    imp_d   = imp_q + NIMP_W'(1);
                end else begin
                    gap_d = gap_q + CMP_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (emit) begin
            smp_d = restart ? '0 : smp_q + TIMP_W'(1);
        end
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            stop_d = 1'b1;
            busy_d = 1'b0;
        end
    end

    // Phase/frequency recurrence and address for the sample being launched.
    // Kept apart from the sequencing block because the chip bit depends on it.
    always_comb begin
        phase_d = phase_q;
        freq_d  = freq_q;
        addr_d  = '0;
        valid_d = 1'b0;
        if (emit) begin
            if (restart) begin
                phase_d = '0;
                freq_d  = fcar_q;
            end else begin
                phase_d = phase_q + freq_q;
                if (mode_q == MODE_LFM) begin
                    freq_d = freq_q + dev_ext;
                end
            end
            valid_d = 1'b1;
            addr_d  = phase_d[PHASE_W-1 -: ADDR_W] ^ (psk_flip ? ADDR_HALF : '0);
        end
    end

    // State, counters, accumulators and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            start_s_q    <= 1'b0;
            start_p_q    <= 1'b0;
            smp_q        <= '0;
            gap_q        <= '0;
            imp_q        <= '0;
            phase_q      <= '0;
            freq_q       <= '0;
            addr_q       <= '0;
            valid_q      <= 1'b0;
            start_calc_q <= 1'b0;
            stop_q       <= 1'b0;
            busy_q       <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_s_q    <= SIGN_START_GEN;
            start_p_q    <= start_s_q;
            smp_q        <= smp_d;
            gap_q        <= gap_d;
            imp_q        <= imp_d;
            phase_q      <= phase_d;
            freq_q       <= freq_d;
            addr_q       <= addr_d;
            valid_q      <= valid_d;
            start_calc_q <= start_calc_d;
            stop_q       <= stop_d;
            busy_q       <= busy_d;
            perr_q       <= perr_d;
        end
    end

    assign ROM_ADDRESS     = addr_q;
    assign ADDR_VALID      = valid_q;
    assign SIGN_START_CALC = start_calc_q;
    assign SIGN_STOP_CALC  = stop_q;
    assign BUSY            = busy_q;
    assign PARAM_ERR       = perr_q;

endmodule

// File: tb/tb_multimode_phase_accum.sv
// Directed self-checking bench for multimode_phase_accum (default parameters).
module tb_multimode_phase_accum;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        SIGN_START_GEN;
    logic [1:0]  SIGNAL_TYPE;
    logic [31:0] F_CARRIER;
    logic [9:0]  T_IMPULSE;
    logic [12:0] T_PERIOD;
    logic [4:0]  NUM_OF_IMP;
    logic [21:0] DEVIATION;
    logic [12:0] PSK_CODE;
    logic [7:0]  CHIP_LEN;
    logic        ABORT;
    logic        OUT_REG_READY;
    logic [11:0] ROM_ADDRESS;
    logic        ADDR_VALID;
    logic        SIGN_START_CALC;
    logic        SIGN_STOP_CALC;
    logic        BUSY;
    logic        PARAM_ERR;

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned exp_q[$];

    multimode_phase_accum dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .SIGN_START_GEN  (SIGN_START_GEN),
        .SIGNAL_TYPE     (SIGNAL_TYPE),
        .F_CARRIER       (F_CARRIER),
        .T_IMPULSE       (T_IMPULSE),
        .T_PERIOD        (T_PERIOD),
        .NUM_OF_IMP      (NUM_OF_IMP),
        .DEVIATION       (DEVIATION),
        .PSK_CODE        (PSK_CODE),
        .CHIP_LEN        (CHIP_LEN),
        .ABORT           (ABORT),
        .OUT_REG_READY   (OUT_REG_READY),
        .ROM_ADDRESS     (ROM_ADDRESS),
        .ADDR_VALID      (ADDR_VALID),
        .SIGN_START_CALC (SIGN_START_CALC),
        .SIGN_STOP_CALC  (SIGN_STOP_CALC),
        .BUSY            (BUSY),
        .PARAM_ERR       (PARAM_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns one negedge later with the request dropped.
    task automatic start_burst(input logic [1:0] typ, input logic [31:0] f,
                               input logic [9:0] ti, input logic [12:0] tp,
                               input logic [4:0] ni, input logic [21:0] dv,
                               input logic [12:0] code, input logic [7:0] cl);
        SIGNAL_TYPE    = typ;
        F_CARRIER      = f;
        T_IMPULSE      = ti;
        T_PERIOD       = tp;
        NUM_OF_IMP     = ni;
        DEVIATION      = dv;
        PSK_CODE       = code;
        CHIP_LEN       = cl;
        SIGN_START_GEN = 1'b1;
        @(negedge CLK);
        SIGN_START_GEN = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int unsigned waited = 0;
        @(negedge CLK);
        while (ADDR_VALID !== 1'b1 && waited < 16) begin
            @(negedge CLK);
            waited++;
        end
        check({tag, "_seen"}, 32'(ADDR_VALID), 32'd1);
    endtask

    // Expects exp_q as one contiguous run of samples, then the stop strobe.
    task automatic expect_samples(input string tag);
        wait_valid(tag);
        foreach (exp_q[i]) begin
            if (i > 0) @(negedge CLK);
            check($sformatf("%s_v%0d", tag, i), 32'(ADDR_VALID), 32'd1);
            check($sformatf("%s_a%0d", tag, i), 32'(ROM_ADDRESS), exp_q[i]);
        end
        @(negedge CLK);
        check({tag, "_stop"}, 32'(SIGN_STOP_CALC), 32'd1);
        check({tag, "_busy"}, 32'(BUSY), 32'd0);
        check({tag, "_vlow"}, 32'(ADDR_VALID), 32'd0);
        @(negedge CLK);
        check({tag, "_stop_end"}, 32'(SIGN_STOP_CALC), 32'd0);
    endtask

    task automatic expect_reject(input string tag);
        @(negedge CLK);
        check({tag, "_perr"}, 32'(PARAM_ERR), 32'd1);
        check({tag, "_busy"}, 32'(BUSY), 32'd0);
        @(negedge CLK);
        check({tag, "_perr_end"}, 32'(PARAM_ERR), 32'd0);
        check({tag, "_busy_end"}, 32'(BUSY), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; SIGN_START_GEN = 1'b0; SIGNAL_TYPE = 2'b00; F_CARRIER = '0;
        T_IMPULSE = '0; T_PERIOD = '0; NUM_OF_IMP = '0; DEVIATION = '0;
        PSK_CODE = '0; CHIP_LEN = '0; ABORT = 1'b0; OUT_REG_READY = 1'b1;

        // Reset values
        @(negedge CLK);
        @(negedge CLK);
        check("rst_addr", 32'(ROM_ADDRESS), 32'd0);
        check("rst_valid", 32'(ADDR_VALID), 32'd0);
        check("rst_start", 32'(SIGN_START_CALC), 32'd0);
        check("rst_stop", 32'(SIGN_STOP_CALC), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_perr", 32'(PARAM_ERR), 32'd0);
        RESET = 1'b0;
        @(negedge CLK);

        // CW with exact latency and strobe placement
        start_burst(2'b00, 32'h0010_0000, 10'd5, 13'd0, 5'd1, 22'd0, 13'd0, 8'd0);
        @(negedge CLK);
        check("cw_busy_arm", 32'(BUSY), 32'd1);
        check("cw_valid_arm", 32'(ADDR_VALID), 32'd0);
        @(negedge CLK);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge CLK);
            check($sformatf("cw_v%0d", k), 32'(ADDR_VALID), 32'd1);
            check($sformatf("cw_a%0d", k), 32'(ROM_ADDRESS), 32'(k));
            check($sformatf("cw_sc%0d", k), 32'(SIGN_START_CALC), (k == 0) ? 32'd1 : 32'd0);
        end
        @(negedge CLK);
        check("cw_stop", 32'(SIGN_STOP_CALC), 32'd1);
        check("cw_busy_end", 32'(BUSY), 32'd0);
        check("cw_vlow", 32'(ADDR_VALID), 32'd0);
        @(negedge CLK);
        check("cw_stop_end", 32'(SIGN_STOP_CALC), 32'd0);

        // LFM up-chirp
        start_burst(2'b01, 32'h0, 10'd5, 13'd0, 5'd1, 22'h100000, 13'd0, 8'd0);
        exp_q = '{0, 0, 1, 3, 6};
        expect_samples("lfm_up");

        // LFM down-chirp (DEVIATION = -0x100000)
        start_burst(2'b01, 32'h0040_0000, 10'd5, 13'd0, 5'd1, 22'h300000, 13'd0, 8'd0);
        exp_q = '{0, 4, 7, 9, 10};
        expect_samples("lfm_dn");

        // PSK
        start_burst(2'b10, 32'h0010_0000, 10'd6, 13'd0, 5'd1, 22'd0, 13'h1F35, 8'd2);
`ifdef MULTIMODE_PSK_EN
        exp_q = '{2048, 2049, 2, 3, 2052, 2053};
        expect_samples("psk");
`else
        expect_reject("psk_off");
`endif

        // Burst with gaps: pulses 8 cycles apart, 3 valid then 5 idle
        start_burst(2'b00, 32'h0010_0000, 10'd3, 13'd8, 5'd3, 22'd0, 13'd0, 8'd0);
        wait_valid("gap");
        for (int c = 0; c < 19; c++) begin
            if (c > 0) @(negedge CLK);
            check($sformatf("gap_v%0d", c), 32'(ADDR_VALID), ((c % 8) < 3) ? 32'd1 : 32'd0);
            check($sformatf("gap_a%0d", c), 32'(ROM_ADDRESS), ((c % 8) < 3) ? 32'(c % 8) : 32'd0);
            check($sformatf("gap_sc%0d", c), 32'(SIGN_START_CALC), (c == 0) ? 32'd1 : 32'd0);
        end
        @(negedge CLK);
        check("gap_stop", 32'(SIGN_STOP_CALC), 32'd1);
        check("gap_busy_end", 32'(BUSY), 32'd0);
        @(negedge CLK);

        // T_PERIOD below T_IMPULSE: back-to-back pulses
        start_burst(2'b00, 32'h0010_0000, 10'd3, 13'd2, 5'd3, 22'd0, 13'd0, 8'd0);
        exp_q = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
        expect_samples("b2b");

        // Rejected requests
        start_burst(2'b00, 32'h0010_0000, 10'd3, 13'd0, 5'd0, 22'd0, 13'd0, 8'd0);
        expect_reject("nimp0");
        start_burst(2'b11, 32'h0010_0000, 10'd3, 13'd0, 5'd1, 22'd0, 13'd0, 8'd0);
        expect_reject("type3");
        start_burst(2'b00, 32'h0010_0000, 10'd0, 13'd0, 5'd1, 22'd0, 13'd0, 8'd0);
        expect_reject("timp0");

        // Abort during the gap
        start_burst(2'b00, 32'h0010_0000, 10'd3, 13'd8, 5'd3, 22'd0, 13'd0, 8'd0);
        wait_valid("abort");
        repeat (4) @(negedge CLK);
        check("abort_in_gap", 32'(ADDR_VALID), 32'd0);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        check("abort_stop", 32'(SIGN_STOP_CALC), 32'd1);
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_valid", 32'(ADDR_VALID), 32'd0);
        @(negedge CLK);
        check("abort_stop_end", 32'(SIGN_STOP_CALC), 32'd0);

        // Output register not ready for 10 cycles
        OUT_REG_READY = 1'b0;
        start_burst(2'b00, 32'h0010_0000, 10'd2, 13'd0, 5'd1, 22'd0, 13'd0, 8'd0);
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            check($sformatf("rdy_hold_v%0d", c), 32'(ADDR_VALID), 32'd0);
        end
        check("rdy_hold_busy", 32'(BUSY), 32'd1);
        OUT_REG_READY = 1'b1;
        @(negedge CLK);
        check("rdy_s0_v", 32'(ADDR_VALID), 32'd1);
        check("rdy_s0_a", 32'(ROM_ADDRESS), 32'd0);
        check("rdy_s0_sc", 32'(SIGN_START_CALC), 32'd1);
        @(negedge CLK);
        check("rdy_s1_a", 32'(ROM_ADDRESS), 32'd1);
        @(negedge CLK);
        check("rdy_stop", 32'(SIGN_STOP_CALC), 32'd1);
        @(negedge CLK);

        // Reset in the middle of a pulse, then a normal burst
        start_burst(2'b00, 32'h0010_0000, 10'd8, 13'd0, 5'd1, 22'd0, 13'd0, 8'd0);
        wait_valid("mrst");
        repeat (2) @(negedge CLK);
        check("mrst_pre_a", 32'(ROM_ADDRESS), 32'd2);
        RESET = 1'b1;
        #1;
        check("mrst_addr", 32'(ROM_ADDRESS), 32'd0);
        check("mrst_valid", 32'(ADDR_VALID), 32'd0);
        check("mrst_busy", 32'(BUSY), 32'd0);
        check("mrst_stop", 32'(SIGN_STOP_CALC), 32'd0);
        check("mrst_start", 32'(SIGN_START_CALC), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check("mrst_idle_stop", 32'(SIGN_STOP_CALC), 32'd0);
        start_burst(2'b00, 32'h0010_0000, 10'd3, 13'd0, 5'd1, 22'd0, 13'd0, 8'd0);
        exp_q = '{0, 1, 2};
        expect_samples("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multimode_phase_accum.md
# multimode_phase_accum

Parametrised successor to the separate LFM and PSK phase accumulators. One block produces ROM sine-table addresses for three modes:
- CW (plain carrier)
- LFM (linear chirp)
- BPSK (arbitrary-length code)

Each run is a burst of NUM_OF_IMP pulses with a programmable pulse length and period. The block sits between the parameter inputs and the signal mux/ROM. It drives the same start/stop strobes consumed by the output register.

## Interface
Parameters:
- PHASE_W, 32: phase and frequency accumulator width.
- ADDR_W, 12: ROM address width. The address is the top ADDR_W bits of the phase.
- TIMP_W, 10: width of T_IMPULSE.
- TPER_W, 13: width of T_PERIOD.
- NIMP_W, 5: width of NUM_OF_IMP.
- DEV_W, 22: width of DEVIATION.
- CODE_LEN, 13: PSK code length in chips.
- CHIP_W, 8: width of CHIP_LEN.

Ports:
- CLK  in  1  system clock. Single clock domain.
- RESET  in  1  asynchronous, active-high reset.
- SIGN_START_GEN  in  1  start request. Acted on at its rising edge.
- SIGNAL_TYPE  in  2  mode select: 00 CW, 01 LFM, 10 PSK, 11 reserved.
- F_CARRIER  in  PHASE_W  initial phase increment.
- T_IMPULSE  in  TIMP_W  pulse length, in clock cycles.
- T_PERIOD  in  TPER_W  pulse repetition period, in clock cycles.
- NUM_OF_IMP  in  NIMP_W  number of pulses per burst.
- DEVIATION  in  DEV_W  signed increment step for LFM, added once per sample.
- PSK_CODE  in  CODE_LEN  PSK chip sequence. Bit 0 is sent first.
- CHIP_LEN  in  CHIP_W  clock cycles per chip. A value of 0 is treated as 1.
- ABORT  in  1  synchronous burst abort.
- OUT_REG_READY  in  1  output register ready to accept a burst.
- ROM_ADDRESS  out  ADDR_W  sine ROM address.
- ADDR_VALID  out  1  ROM_ADDRESS carries a sample.
- SIGN_START_CALC  out  1  one-cycle strobe on the first sample of the burst.
- SIGN_STOP_CALC  out  1  one-cycle strobe when the burst ends.
- BUSY  out  1  a burst is accepted and not yet finished.
- PARAM_ERR  out  1  one-cycle strobe when a start request is rejected.

## Operation
- State machine states: IDLE, ARM, PULSE, GAP, DONE.
- Reset values: state IDLE; ROM_ADDRESS 0; all 1-bit outputs 0.
- **IDLE**
  - On a SIGN_START_GEN rising edge, check the parameters.
  - Reject the request if SIGNAL_TYPE is 11, T_IMPULSE is 0 or NUM_OF_IMP is 0. On reject, pulse PARAM_ERR and stay in IDLE.
  - Otherwise latch all parameters, set BUSY and go to ARM.
- **ARM**
  - Wait for OUT_REG_READY = 1, then go to PULSE.
  - ABORT in ARM goes to DONE.
- **PULSE**
  - One sample per cycle; ADDR_VALID = 1.
  - Recurrence: phase_0 = 0, freq_0 = F_CARRIER, phase_{k+1} = phase_k + freq_k.
  - LFM only: freq_{k+1} = freq_k + sign-extended DEVIATION.
  - CW and PSK: freq stays constant.
  - Both accumulators wrap modulo 2^PHASE_W.
  - ROM_ADDRESS = phase_k[PHASE_W-1 -: ADDR_W].
  - PSK only: add 2^(ADDR_W-1) to the address, modulo 2^ADDR_W, when the current chip bit is 1.
  - PSK chip handling:
    - The chip index advances every CHIP_LEN samples.
    - The index wraps to 0 after CODE_LEN-1.
    - The index restarts at 0 on every pulse.
- **End of a pulse** (after T_IMPULSE samples):
  - If this was the last pulse, go to DONE.
  - Else if T_PERIOD > T_IMPULSE, go to GAP.
  - Else start the next pulse back-to-back in PULSE.
- **GAP**
  - ADDR_VALID = 0 and ROM_ADDRESS = 0 for T_PERIOD − T_IMPULSE cycles.
  - Then go to PULSE with phase, freq and chip index re-initialised.
- **DONE**
  - Pulse SIGN_STOP_CALC for one cycle, clear BUSY, go to IDLE.
- ABORT in PULSE or GAP: the next cycle is DONE.
- SIGN_START_GEN edges while BUSY are ignored and not queued.
- Parameter inputs are sampled only at accept time, so changes during a burst have no effect.
- RESET asserted mid-burst: outputs return to their reset values immediately, with no stop strobe.

## Timing
- All outputs are registered.
- The edge that enters PULSE for the first pulse sets all three of:
  - SIGN_START_CALC = 1 (for one cycle);
  - ADDR_VALID = 1;
  - ROM_ADDRESS = sample 0.
- Sample k appears k cycles after sample 0.
- ADDR_VALID stays high for exactly T_IMPULSE cycles per pulse.
- Pulse i+1 starts exactly max(T_PERIOD, T_IMPULSE) cycles after pulse i starts.
- SIGN_STOP_CALC is high in the cycle after the last valid sample; BUSY falls with it.
- Latency from the SIGN_START_GEN edge (with OUT_REG_READY already high) to sample 0 is 2 cycles.

## Configuration
- Macro MULTIMODE_PSK_EN.
- When defined: PSK mode is as described above.
- When undefined:
  - SIGNAL_TYPE 10 is rejected like 11.
  - PSK_CODE and CHIP_LEN stay as ports but are ignored.
  - No chip counter logic is synthesised.

## Structure
- Shared package holds:
  - the mode encoding constants (CW, LFM, PSK, reserved);
  - the state enum typedef;
  - the default parameter values.
- One natural sub-module: psk_chip_sequencer, containing the chip timer, the code index and the current chip bit. It is instantiated under MULTIMODE_PSK_EN only.

## Test plan
All scenarios use default parameters.
- **CW:** F_CARRIER = 0x0010_0000, T_IMPULSE = 5, NUM_OF_IMP = 1 -> addresses 0,1,2,3,4 with ADDR_VALID high for 5 cycles; SIGN_START_CALC on the first sample; SIGN_STOP_CALC one cycle after the last.
- **LFM:** F_CARRIER = 0, DEVIATION = 0x100000, T_IMPULSE = 5 -> addresses 0,0,1,3,6. With DEVIATION = −0x100000 and F_CARRIER = 0x0040_0000 -> addresses 0,4,7,9,10.
- **PSK:** PSK_CODE = 0x1F35, CODE_LEN = 13, CHIP_LEN = 2, F_CARRIER = 0x0010_0000, T_IMPULSE = 6 -> addresses 2048,2049,2,3,2052,2053.
- **Burst:** T_IMPULSE = 3, T_PERIOD = 8, NUM_OF_IMP = 3 -> pulses start 8 cycles apart with 5-cycle gaps and restart at address 0. With T_PERIOD = 2 -> 9 contiguous valid cycles.
- **Rejects and abort:**
  - NUM_OF_IMP = 0 -> PARAM_ERR pulse, BUSY stays 0.
  - SIGNAL_TYPE = 11 -> PARAM_ERR pulse.
  - ABORT during GAP -> SIGN_STOP_CALC next cycle.
- **Handshake and reset:**
  - OUT_REG_READY held low for 10 cycles -> no samples; sample 0 appears on the edge after READY rises.
  - RESET mid-pulse -> all outputs 0 at once; a new start after reset behaves normally.
